// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller request path.
package mem_ctrl_pkg;

    // Request sequencer states: waiting for the core, owning the bus, reporting completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } req_state_t;

    // Core words are 16 bits, so only the low two byte lanes are ever selected.
    localparam logic [3:0]  WB_SEL_HALF       = 4'b0011;

    // Wishbone byte address of core word 0 on the Caravel user bus.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    // Converts a 16-bit core word address into a Wishbone byte address.
    function automatic logic [31:0] word_to_wb_addr(input logic [31:0] base,
                                                    input logic [15:0] word_addr);
        return base + {14'b0, word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_requester_if.sv
// Wishbone classic bus between the request stage (master) and the Caravel slave.
interface mem_bus_requester_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Watchdog for a single bus transaction: counts wait cycles and flags the last allowed one.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_q holds how many bus cycles have already elapsed, so when it reaches
    // TIMEOUT_CYCLES-1 the current cycle is the final one in which an ack is accepted.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign expired = (count_q >= LAST_WAIT);

    // Clear has priority; the count saturates at the limit instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bus_requester.sv
// Turns the core's level-held read/write request into one Wishbone classic
// transaction and hands the result to the completion stage.
module mem_bus_requester
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_read_en,
    input  logic                       cpu_write_en,
    input  logic [15:0]                cpu_addr,
    input  logic [15:0]                cpu_wdata,
    mem_bus_requester_if.master        wb,
    output logic                       mem_read_en,
    output logic                       mem_write_en,
    output logic                       cmp_o,
    output logic [15:0]                next_data,
    output logic                       timeout_err
);

    req_state_t  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic        cmp_q, cmp_d;
    logic        timeout_q, timeout_d;
    logic [15:0] next_data_q, next_data_d;

    logic        expired;
    logic [15:0] wb_dat_unused;

    // Only the low half of the slave data carries a core word.
    assign wb_dat_unused = wb.wb_dat_i[31:16];

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q == BUS),
        .expired (expired)
    );

    // Next-state and output logic; everything is latched so bus outputs ignore input changes mid-transaction.
    always_comb begin
        state_d        = state_q;
        adr_d          = adr_q;
        dat_d          = dat_q;
        sel_d          = sel_q;
        we_d           = we_q;
        cyc_d          = cyc_q;
        mem_read_en_d  = mem_read_en_q;
        mem_write_en_d = mem_write_en_q;
        cmp_d          = 1'b0;
        timeout_d      = 1'b0;
        next_data_d    = next_data_q;

        case (state_q)
            IDLE: begin
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
                if (cpu_read_en || cpu_write_en) begin
                    // A read wins when both enables are high; the write is dropped.
                    state_d        = BUS;
                    adr_d          = word_to_wb_addr(BASE_ADDR, cpu_addr);
                    dat_d          = {16'h0000, cpu_wdata};
                    sel_d          = WB_SEL_HALF;
                    we_d           = !cpu_read_en;
                    cyc_d          = 1'b1;
                    mem_read_en_d  = cpu_read_en;
                    mem_write_en_d = !cpu_read_en;
                end
            end
            BUS: begin
                if (wb.wb_ack_i || expired) begin
                    state_d = DONE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    cmp_d   = 1'b1;
                    if (wb.wb_ack_i) begin
                        if (mem_read_en_q) begin
                            next_data_d = wb.wb_dat_i[15:0];
                        end
                    end else begin
                        timeout_d = 1'b1;
                        if (mem_read_en_q) begin
                            next_data_d = 16'h0000;
                        end
                    end
                end
            end
            DONE: begin
                state_d        = IDLE;
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately, aborting any slave wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            adr_q          <= '0;
            dat_q          <= '0;
            sel_q          <= '0;
            we_q           <= 1'b0;
            cyc_q          <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            cmp_q          <= 1'b0;
            timeout_q      <= 1'b0;
            next_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            adr_q          <= adr_d;
            dat_q          <= dat_d;
            sel_q          <= sel_d;
            we_q           <= we_d;
            cyc_q          <= cyc_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            cmp_q          <= cmp_d;
            timeout_q      <= timeout_d;
            next_data_q    <= next_data_d;
        end
    end

    assign wb.wb_adr_o   = adr_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_sel_o   = sel_q;
    assign wb.wb_we_o    = we_q;
    assign wb.wb_cyc_o   = cyc_q;
    assign wb.wb_stb_o   = cyc_q;
    assign mem_read_en   = mem_read_en_q;
    assign mem_write_en  = mem_write_en_q;
    assign cmp_o         = cmp_q;
    assign timeout_err   = timeout_q;
    assign next_data     = next_data_q;

endmodule

// File: tb/tb_mem_bus_requester.sv
// Self-checking bench for mem_bus_requester with a small Wishbone slave model
// and a scoreboard of expected completions.
module tb_mem_bus_requester;
    import mem_ctrl_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read_en, cpu_write_en;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        mem_read_en, mem_write_en, cmp_o, timeout_err;
    logic [15:0] next_data;

    mem_bus_requester_if bus ();

    mem_bus_requester #(
        .BASE_ADDR      (32'h3000_0000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read_en  (cpu_read_en),
        .cpu_write_en (cpu_write_en),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .wb           (bus.master),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .cmp_o        (cmp_o),
        .next_data    (next_data),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        tmo;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Slave model: acks in bus cycle ack_wait+1 unless ack_never; stray_ack drives ack outside a transaction.
    int          ack_wait   = 0;
    bit          ack_never  = 1'b0;
    bit          stray_ack  = 1'b0;
    logic [31:0] slave_data = 32'h0;
    int          bus_cycles = 0;

    always @(negedge clk) begin
        bus.wb_dat_i = slave_data;
        if (bus.wb_cyc_o === 1'b1) begin
            bus_cycles   = bus_cycles + 1;
            bus.wb_ack_i = !ack_never && (bus_cycles == ack_wait + 1);
        end else begin
            bus_cycles   = 0;
            bus.wb_ack_i = stray_ack;
        end
    end

    function automatic logic [90:0] all_outs();
        return {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o,
                bus.wb_stb_o, mem_read_en, mem_write_en, cmp_o, next_data, timeout_err};
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        cpu_read_en  = rd;
        cpu_write_en = wr;
        cpu_addr     = a;
        cpu_wdata    = d;
    endtask

    task automatic drop_enables();
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
    endtask

    task automatic wait_cmp(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (cmp_o !== 1'b1 && waited < budget);
    endtask

    task automatic test_reset();
        logic [90:0] o;
        rst = 1'b1;
        drop_enables();
        cpu_addr  = '0;
        cpu_wdata = '0;
        #1;
        o = all_outs();
        tests_run++;
        if (o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h want 0", o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int   waited;
        exp_t e;
        ack_wait   = 0;
        slave_data = 32'hDEAD_BEEF;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b0, data: 16'hBEEF});
        issue(1'b1, 1'b0, 16'h0004, 16'h0000);
        @(negedge clk);
        tests_run++;
        if ({bus.wb_adr_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, mem_read_en}
            !== {32'h3000_0010, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL read_issue: adr=%h cyc=%b stb=%b we=%b sel=%b rd=%b want adr=30000010 cyc=1 stb=1 we=0 sel=0011 rd=1",
                     bus.wb_adr_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, mem_read_en);
        end
        wait_cmp(8, waited);
        tests_run++;
        if (cmp_o !== 1'b1 || waited != 1 || bus.wb_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_latency: cmp=%b cycle=%0d cyc=%b want cmp=1 cycle=2 cyc=0", cmp_o, waited + 1, bus.wb_cyc_o);
        end
        e = sb_q.pop_front();
        tests_run++;
        if ({mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL read_result: got rd=%b wr=%b tmo=%b data=%h want rd=%b wr=%b tmo=%b data=%h",
                     mem_read_en, mem_write_en, timeout_err, next_data, e.rd, e.wr, e.tmo, e.data);
        end
        drop_enables();
        @(negedge clk);
        tests_run++;
        if ({cmp_o, mem_read_en, next_data} !== {1'b0, 1'b0, 16'hBEEF}) begin
            tests_failed++;
            $display("[TB] FAIL read_hold: cmp=%b rd=%b data=%h want cmp=0 rd=0 data=beef", cmp_o, mem_read_en, next_data);
        end
    endtask

    task automatic test_write_wait_states();
        int   waited;
        exp_t e;
        ack_wait   = 3;
        slave_data = 32'hFFFF_9999;
        sb_q.push_back('{rd: 1'b0, wr: 1'b1, tmo: 1'b0, data: 16'hBEEF});
        issue(1'b0, 1'b1, 16'h0001, 16'h1234);
        @(negedge clk);
        tests_run++;
        if ({bus.wb_we_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_cyc_o, bus.wb_adr_o}
            !== {1'b1, 32'h0000_1234, 4'b0011, 1'b1, 32'h3000_0004}) begin
            tests_failed++;
            $display("[TB] FAIL write_issue: we=%b dat=%h sel=%b cyc=%b adr=%h want we=1 dat=00001234 sel=0011 cyc=1 adr=30000004",
                     bus.wb_we_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_cyc_o, bus.wb_adr_o);
        end
        wait_cmp(10, waited);
        tests_run++;
        if (cmp_o !== 1'b1 || waited != 4) begin
            tests_failed++;
            $display("[TB] FAIL write_latency: cmp=%b cycle=%0d want cmp=1 cycle=5", cmp_o, waited + 1);
        end
        e = sb_q.pop_front();
        tests_run++;
        if ({mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL write_result: got rd=%b wr=%b tmo=%b data=%h want rd=%b wr=%b tmo=%b data=%h",
                     mem_read_en, mem_write_en, timeout_err, next_data, e.rd, e.wr, e.tmo, e.data);
        end
        drop_enables();
        @(negedge clk);
    endtask

    task automatic test_both_high();
        int   waited;
        exp_t e;
        ack_wait   = 1;
        slave_data = 32'h0000_CAFE;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b0, data: 16'hCAFE});
        issue(1'b1, 1'b1, 16'h0002, 16'h5555);
        @(negedge clk);
        tests_run++;
        if ({bus.wb_we_o, mem_read_en, mem_write_en, bus.wb_adr_o} !== {1'b0, 1'b1, 1'b0, 32'h3000_0008}) begin
            tests_failed++;
            $display("[TB] FAIL both_high_issue: we=%b rd=%b wr=%b adr=%h want we=0 rd=1 wr=0 adr=30000008",
                     bus.wb_we_o, mem_read_en, mem_write_en, bus.wb_adr_o);
        end
        cpu_addr  = 16'hFFFF;
        cpu_wdata = 16'h0000;
        @(negedge clk);
        tests_run++;
        if ({bus.wb_cyc_o, bus.wb_adr_o} !== {1'b1, 32'h3000_0008}) begin
            tests_failed++;
            $display("[TB] FAIL addr_latched: cyc=%b adr=%h want cyc=1 adr=30000008", bus.wb_cyc_o, bus.wb_adr_o);
        end
        wait_cmp(8, waited);
        e = sb_q.pop_front();
        tests_run++;
        if (cmp_o !== 1'b1 || waited != 1 ||
            {mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL both_high_result: cmp=%b cycle=%0d rd=%b wr=%b tmo=%b data=%h want cmp=1 cycle=3 rd=%b wr=%b tmo=%b data=%h",
                     cmp_o, waited + 2, mem_read_en, mem_write_en, timeout_err, next_data, e.rd, e.wr, e.tmo, e.data);
        end
        drop_enables();
        @(negedge clk);
    endtask

    task automatic test_late_ack();
        stray_ack  = 1'b1;
        slave_data = 32'h0000_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.wb_cyc_o, cmp_o, mem_read_en, next_data} !== {1'b0, 1'b0, 1'b0, 16'hCAFE}) begin
                tests_failed++;
                $display("[TB] FAIL late_ack_ignored: cyc=%b cmp=%b rd=%b data=%h want cyc=0 cmp=0 rd=0 data=cafe",
                         bus.wb_cyc_o, cmp_o, mem_read_en, next_data);
            end
        end
        stray_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        logic [90:0] o;
        ack_never = 1'b1;
        issue(1'b0, 1'b1, 16'h0009, 16'hAAAA);
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.wb_cyc_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_bus_pre: cyc=%b want 1", bus.wb_cyc_o);
        end
        #1 rst = 1'b1;
        drop_enables();
        #1;
        o = all_outs();
        tests_run++;
        if (o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_outputs: got %h want 0", o);
        end
        @(negedge clk);
        rst       = 1'b0;
        ack_never = 1'b0;
        tests_run++;
        if (dut.state_q !== IDLE) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.wb_cyc_o, cmp_o, next_data} !== {1'b0, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("[TB] FAIL reset_after: cyc=%b cmp=%b data=%h want cyc=0 cmp=0 data=0000", bus.wb_cyc_o, cmp_o, next_data);
        end
    endtask

    task automatic test_back_to_back();
        int   waited;
        exp_t e;
        ack_wait   = 0;
        slave_data = 32'h0000_0A0A;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b0, data: 16'h0A0A});
        issue(1'b1, 1'b0, 16'h0020, 16'h0000);
        wait_cmp(8, waited);
        e = sb_q.pop_front();
        tests_run++;
        if (cmp_o !== 1'b1 || waited != 2 ||
            {mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: cmp=%b cycle=%0d data=%h want cmp=1 cycle=2 data=%h", cmp_o, waited, next_data, e.data);
        end
        slave_data = 32'h0000_0B0B;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b0, data: 16'h0B0B});
        @(negedge clk);
        tests_run++;
        if ({bus.wb_cyc_o, mem_read_en, cmp_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle_gap: cyc=%b rd=%b cmp=%b want 0 0 0", bus.wb_cyc_o, mem_read_en, cmp_o);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.wb_cyc_o, bus.wb_adr_o} !== {1'b1, 32'h3000_0080}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_reissue: cyc=%b adr=%h want cyc=1 adr=30000080", bus.wb_cyc_o, bus.wb_adr_o);
        end
        wait_cmp(8, waited);
        drop_enables();
        e = sb_q.pop_front();
        tests_run++;
        if (cmp_o !== 1'b1 || waited != 1 ||
            {mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: cmp=%b waited=%0d data=%h want cmp=1 waited=1 data=%h", cmp_o, waited, next_data, e.data);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.wb_cyc_o !== 1'b0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_stop: cyc=%b pending=%0d want cyc=0 pending=0", bus.wb_cyc_o, sb_q.size());
        end
    endtask

    task automatic test_ack_at_limit();
        int   waited;
        exp_t e;
        ack_wait   = TMO - 1;
        slave_data = 32'h0000_7777;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b0, data: 16'h7777});
        issue(1'b1, 1'b0, 16'h0030, 16'h0000);
        wait_cmp(10, waited);
        e = sb_q.pop_front();
        tests_run++;
        if (cmp_o !== 1'b1 || waited != TMO + 1 ||
            {mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL ack_at_limit: cmp=%b cycle=%0d tmo=%b data=%h want cmp=1 cycle=%0d tmo=0 data=%h",
                     cmp_o, waited, timeout_err, next_data, TMO + 1, e.data);
        end
        drop_enables();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        ack_never = 1'b1;
        sb_q.push_back('{rd: 1'b1, wr: 1'b0, tmo: 1'b1, data: 16'h0000});
        issue(1'b1, 1'b0, 16'h0040, 16'h0000);
        repeat (TMO) @(negedge clk);
        tests_run++;
        if ({bus.wb_cyc_o, cmp_o} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL timeout_last_wait: cyc=%b cmp=%b want cyc=1 cmp=0", bus.wb_cyc_o, cmp_o);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        tests_run++;
        if (bus.wb_cyc_o !== 1'b0 || cmp_o !== 1'b1 ||
            {mem_read_en, mem_write_en, timeout_err, next_data} !== {e.rd, e.wr, e.tmo, e.data}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_done: cyc=%b cmp=%b rd=%b tmo=%b data=%h want cyc=0 cmp=1 rd=1 tmo=1 data=%h",
                     bus.wb_cyc_o, cmp_o, mem_read_en, timeout_err, next_data, e.data);
        end
        drop_enables();
        @(negedge clk);
        tests_run++;
        if ({timeout_err, cmp_o} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL timeout_pulse: tmo=%b cmp=%b want 0 0", timeout_err, cmp_o);
        end
        ack_never = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait_states();
        test_both_high();
        test_late_ack();
        test_reset_mid_bus();
        test_back_to_back();
        test_ack_at_limit();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
